piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_tx.sv | 126 ++++++++++++
 tb/tb_piso_tx.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with registered frame/done flags.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q_out,
    output logic             frame,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_TX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] sreg_sh;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             last;
    logic             head;
    logic             done_nxt;
`ifdef PISO_TX_PARITY_EN
    logic             par;
    logic             par_nxt;
`endif

    assign last = (cnt == CW'(WIDTH - 1));

    // Head and shift direction are fixed by MSB_FIRST at elaboration.
    assign head    = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign sreg_sh = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                               : {1'b0, sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
`ifdef PISO_TX_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_nxt   = par;
`endif
        unique case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = din;
                    cnt_nxt   = '0;
`ifdef PISO_TX_PARITY_EN
                    par_nxt   = ^din;
`endif
                end
            end
            SHIFT: begin
                sreg_nxt = sreg_sh;
                cnt_nxt  = cnt + CW'(1);
                if (last) begin
`ifdef PISO_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; no input reaches them.
    assign load_ready = (state == IDLE);
    assign frame      = (state != IDLE);
`ifdef PISO_TX_PARITY_EN
    assign q_out = ((state == SHIFT) & head) | ((state == PARITY) & par);
`else
    assign q_out = (state == SHIFT) & head;
`endif

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: MSB-first and LSB-first instances driven in parallel and checked
// every cycle against a frame-timeline model plus literal expectations.
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FL = W + P;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         load_valid;
    logic         rdy_m, q_m, frm_m, dn_m;
    logic         rdy_l, q_l, frm_l, dn_l;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(rdy_m), .q_out(q_m), .frame(frm_m), .done(dn_m)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
        .load_ready(rdy_l), .q_out(q_l), .frame(frm_l), .done(dn_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit started = 1'b0;

    // Literal expectations keyed by cycle number (cycle c follows edge c-1).
    logic lq_m[int];
    logic lq_l[int];
    logic lf_m[int];
    logic ld_m[int];
    logic ld_l[int];
    logic lr_m[int];

    // Model: pos = cycles since load (0..FL-1 frame, FL = done cycle), -1 idle.
    int       pos = -1;
    logic [W-1:0] word = '0;

    task automatic chk(input string nm, input int c,
                       input logic a, input logic e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%b want=%b", nm, c, a, e);
        end
    endtask

    always @(posedge clk) begin
        int   c;
        bit   rdy_e, frm_e, dn_e;
        logic qm_e, ql_e;
        rdy_e = (pos < 0) || (pos == FL);
        if (rst) begin
            pos = -1;
            started = 1'b1;
        end else if (rdy_e && load_valid) begin
            pos  = 0;
            word = din;
        end else if (pos >= 0 && pos < FL) begin
            pos = pos + 1;
        end else begin
            pos = -1;
        end
        cyc = cyc + 1;
        c = cyc + 1;
        #1;
        if (started) begin
            frm_e = (pos >= 0) && (pos < FL);
            dn_e  = (pos == FL);
            rdy_e = !frm_e;
            qm_e  = 1'b0;
            ql_e  = 1'b0;
            if (pos >= 0 && pos < W) begin
                qm_e = word[W-1-pos];
                ql_e = word[pos];
            end else if (P == 1 && pos == W) begin
                qm_e = ^word;
                ql_e = ^word;
            end
            chk("q_msb", c, q_m, qm_e);
            chk("q_lsb", c, q_l, ql_e);
            chk("frame_msb", c, frm_m, frm_e);
            chk("frame_lsb", c, frm_l, frm_e);
            chk("done_msb", c, dn_m, dn_e);
            chk("done_lsb", c, dn_l, dn_e);
            chk("ready_msb", c, rdy_m, rdy_e);
            chk("ready_lsb", c, rdy_l, rdy_e);
            if (lq_m.exists(c)) chk("lit_q_msb", c, q_m, lq_m[c]);
            if (lq_l.exists(c)) chk("lit_q_lsb", c, q_l, lq_l[c]);
            if (lf_m.exists(c)) chk("lit_frame", c, frm_m, lf_m[c]);
            if (ld_m.exists(c)) chk("lit_done_msb", c, dn_m, ld_m[c]);
            if (ld_l.exists(c)) chk("lit_done_lsb", c, dn_l, ld_l[c]);
            if (lr_m.exists(c)) chk("lit_ready", c, rdy_m, lr_m[c]);
        end
    end

    // 8'hC1 frame loaded at edge n: hand-written bit orders for both instances.
    task automatic lit_c1(input int n);
        logic seq_m[W] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic seq_l[W] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < W; k++) begin
            lq_m[n+1+k] = seq_m[k];
            lq_l[n+1+k] = seq_l[k];
            lf_m[n+1+k] = 1'b1;
            ld_m[n+1+k] = 1'b0;
            ld_l[n+1+k] = 1'b0;
        end
`ifdef PISO_TX_PARITY_EN
        lq_m[n+9] = 1'b1;
        lq_l[n+9] = 1'b1;
        lf_m[n+9] = 1'b1;
        ld_m[n+9] = 1'b0;
`endif
        ld_m[n+9+P]  = 1'b1;
        ld_l[n+9+P]  = 1'b1;
        lr_m[n+9+P]  = 1'b1;
        ld_m[n+10+P] = 1'b0;
    endtask

    initial begin
        int n;
        logic [W-1:0] words[4] = '{8'h00, 8'h5A, 8'h81, 8'hFF};
        rst = 1'b1;
        load_valid = 1'b0;
        din = '0;
        lr_m[2] = 1'b1;
        lf_m[2] = 1'b0;
        lq_m[2] = 1'b0;
        ld_m[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single 8'hC1 frame; din changes right after the load edge.
        load_valid = 1'b1;
        din = 8'hC1;
        n = cyc + 1;
        lit_c1(n);
        @(negedge clk);
        load_valid = 1'b0;
        din = 8'h3C;
        repeat (FL + 3) @(negedge clk);

        // load_valid held high with 8'hFF during the 8'hC1 frame.
        load_valid = 1'b1;
        din = 8'hC1;
        n = cyc + 1;
        lit_c1(n);
        for (int k = 0; k < W; k++) begin
            lq_m[n+FL+2+k] = 1'b1;
            lq_l[n+FL+2+k] = 1'b1;
            lf_m[n+FL+2+k] = 1'b1;
        end
        @(negedge clk);
        din = 8'hFF;
        repeat (FL + 1) @(negedge clk);
        load_valid = 1'b0;
        repeat (FL + 3) @(negedge clk);

        // Reset after bit 3 of an 8'hF0 frame aborts it with no done pulse.
        load_valid = 1'b1;
        din = 8'hF0;
        n = cyc + 1;
        lq_m[n+4] = 1'b1;
        lq_l[n+4] = 1'b0;
        lf_m[n+4] = 1'b1;
        lq_m[n+5] = 1'b0;
        lf_m[n+5] = 1'b0;
        lr_m[n+5] = 1'b1;
        for (int c = n + 5; c < n + 16; c++) ld_m[c] = 1'b0;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (FL + 3) @(negedge clk);

        // Load coinciding with reset is dropped.
        rst = 1'b1;
        load_valid = 1'b1;
        din = 8'hC1;
        n = cyc + 1;
        lf_m[n+1] = 1'b0;
        lf_m[n+2] = 1'b0;
        lq_m[n+1] = 1'b0;
        lr_m[n+1] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Back-to-back frames, each loaded in the previous done cycle.
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            din = words[i];
            @(negedge clk);
            load_valid = 1'b0;
            din = ~words[i];
            repeat (FL) @(negedge clk);
        end
        repeat (FL + 4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
